reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one 8-bit enable-loaded register (ports CLK, RST, ENA, DATA, R) among N requesters.
- Round-robin arbitration with a 4-phase REQ/ACK handshake.
- Drives the register's ENA and DATA, then reads back R to check that each write landed. A mismatch sets a sticky error flag.
- Sits between the requesting control blocks and the register instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-low (0 = reset, sampled on CLK rising edge).
- REQ  in  N_REQ  per-requester write request, level, held until ACK seen.
- WDATA  in  N_REQ*WIDTH  requester write data; slice i = WDATA[i*WIDTH +: WIDTH].
- R_IN  in  WIDTH  readback from register output R.
- REG_ENA  out  1  register load enable.
- REG_DATA  out  WIDTH  register data input.
- GNT  out  N_REQ  one-hot grant, held WRITE through RELEASE.
- ACK  out  N_REQ  one-cycle write-complete pulse to the granted requester.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky readback-mismatch flag.

Behaviour:
- Reset (RST=0 at an edge):
  - State goes to IDLE and PTR to 0.
  - REG_ENA, REG_DATA, GNT, ACK, BUSY and ERR all go to 0.
  - Applies mid-transaction: the write in flight is abandoned and no ACK is issued.
- FSM states:
  - IDLE:
    - Sample REQ.
    - If any bit is set, pick the winner w: the first set bit searching PTR, PTR+1, ... mod N_REQ.
    - Latch data_q = WDATA slice w and idx = w, then go to WRITE.
    - With no request, stay in IDLE.
  - WRITE (1 cycle): GNT[idx]=1, REG_ENA=1, REG_DATA=data_q, then go to CHECK.
  - CHECK (1 cycle):
    - The register has captured data_q at the previous edge.
    - ACK[idx]=1.
    - If R_IN != data_q, set ERR=1 at the edge ending CHECK.
    - Set PTR = (idx+1) mod N_REQ, then go to RELEASE.
  - RELEASE:
    - GNT[idx] stays 1.
    - Wait until REQ[idx]==0, then go to IDLE; no timeout.
- Outputs are registered from the state and are glitch-free.
- REG_ENA is high for exactly one cycle per grant. REG_DATA holds data_q until the next grant; it is 0 only after reset.
- Latency: REQ high at edge E0 (in IDLE) gives:
  - REG_ENA high for the cycle E0..E1;
  - register updated at E1;
  - ACK high for the cycle E1..E2.
  - Minimum request-to-request turnaround is 4 cycles.
- Boundaries:
  - Simultaneous requests: exactly one winner, per PTR order. Losers keep REQ high and are served in subsequent rounds. No requester waits more than N_REQ-1 grants.
  - REQ[idx] dropped during WRITE or CHECK: the transaction still completes and ACK still pulses.
  - REQ changes on non-granted lines outside IDLE are ignored.
  - WDATA changes after IDLE sampling have no effect; data_q is frozen.
  - PTR wraps from N_REQ-1 to 0.
  - ERR clears only on reset.

Decomposition:
- Shared package reg_arb_pkg:
  - state enum {IDLE, WRITE, CHECK, RELEASE}, 2-bit encoding;
  - IDX_W = $clog2(N_REQ) constant/function.
- One sub-module rr_pick (combinational): inputs REQ and PTR; outputs valid and winner index.

Test Plan:
- Reset: hold RST=0 for 2 cycles while REQ=4'b1111 → GNT=0, ACK=0, REG_ENA=0, BUSY=0. After release, the first grant goes to requester 0.
- Single write:
  - Stimulus: REQ[2]=1, WDATA slice 2 = 8'hAA.
  - Response: REG_ENA for 1 cycle with REG_DATA=8'hAA; R=8'hAA next edge; ACK[2] pulses 1 cycle after ENA; GNT[2] held until REQ[2] drops; ERR=0.
- Round-robin fairness:
  - Stimulus: REQ=4'b1111 held throughout, each requester dropping REQ after its ACK, data 8'h0F, 8'hF0, 8'hFF, 8'h55 for slices 0..3.
  - Response: grants in order 0,1,2,3; final R=8'h55.
- Wrap:
  - Stimulus: after a grant to 3, REQ=4'b1001.
  - Response: grant goes to 0, then to 3.
- Readback error: force R_IN=8'h00 while writing 8'hAA → ERR=1 after CHECK and stays 1 through further good writes.
- Reset mid-operation:
  - Stimulus: RST=0 during the WRITE cycle.
  - Response: no ACK, state IDLE, PTR=0, ERR cleared; a later REQ completes normally.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        CHECK   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] winner
);

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid  = |req;
        winner = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            for (int i = 0; i < int'(N); i++) begin
                if (req[i] && (((int'(ptr) + k) % int'(N)) == i)) begin
                    winner = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates N requesters onto one enable-loaded register and verifies each write by readback.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] WDATA,
    input  logic [WIDTH-1:0]       R_IN,
    output logic                   REG_ENA,
    output logic [WIDTH-1:0]       REG_DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       ACK,
    output logic                   BUSY,
    output logic                   ERR
);

    localparam int unsigned IDX_W = idx_w(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ena_d;
    logic [WIDTH-1:0] reg_data_d;
    logic [N_REQ-1:0] gnt_d;
    logic [N_REQ-1:0] ack_d;
    logic             busy_d;
    logic             err_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] wdata_sel;
    logic [IDX_W-1:0] ptr_next;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    rr_pick #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_pick (
        .req    (REQ),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Data slice of the current round-robin winner.
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx == IDX_W'(i)) begin
                wdata_sel = WDATA[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(idx_q + IDX_W'(1));

    // Next state and next registered outputs; outputs are loaded on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        ena_d      = 1'b0;
        reg_data_d = REG_DATA;
        gnt_d      = GNT;
        ack_d      = '0;
        err_d      = ERR;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    idx_d      = pick_idx;
                    data_d     = wdata_sel;
                    reg_data_d = wdata_sel;
                    ena_d      = 1'b1;
                    gnt_d      = onehot(pick_idx);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                ack_d   = onehot(idx_q);
                state_d = CHECK;
            end
            CHECK: begin
                if (R_IN != data_q) begin
                    err_d = 1'b1;
                end
                ptr_d   = ptr_next;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!REQ[idx_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            REG_ENA  <= 1'b0;
            REG_DATA <= '0;
            GNT      <= '0;
            ACK      <= '0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            REG_ENA  <= ena_d;
            REG_DATA <= reg_data_d;
            GNT      <= gnt_d;
            ACK      <= ack_d;
            BUSY     <= busy_d;
            ERR      <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: randomized requesters, a round-robin reference model and a write monitor.
module tb_reg_write_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] WDATA;
    logic [W-1:0]   R_IN;
    logic           REG_ENA;
    logic [W-1:0]   REG_DATA;
    logic [N-1:0]   GNT;
    logic [N-1:0]   ACK;
    logic           BUSY;
    logic           ERR;

    logic [W-1:0]   reg_r;
    bit             corrupt;
    bit             mon_en;
    bit             early_ok;
    int             mstep;
    int             n_cmp;
    int             n_err;
    int             model_ptr;
    bit             model_err;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    reg_write_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .WDATA    (WDATA),
        .R_IN     (R_IN),
        .REG_ENA  (REG_ENA),
        .REG_DATA (REG_DATA),
        .GNT      (GNT),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // The shared register itself, with an optional stuck-at-zero readback path.
    always @(posedge CLK) begin
        if (!RST) reg_r <= '0;
        else if (REG_ENA) reg_r <= REG_DATA;
    end
    assign R_IN = corrupt ? '0 : reg_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: serve every requester in mask once, nearest-from-pointer first.
    task automatic model_push(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        exp_t e;
        int w;
        pend = mask;
        while (pend != '0) begin
            w = -1;
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (model_ptr + k) % int'(N);
                if (w < 0 && pend[j]) w = j;
            end
            e.idx  = w;
            e.data = WDATA[w*W +: W];
            model_err = model_err | (corrupt && e.data != 8'h00);
            e.err  = model_err;
            sb.push_back(e);
            pend[w]   = 1'b0;
            model_ptr = (w + 1) % int'(N);
        end
    endtask

    task automatic issue(input logic [N-1:0] mask);
        REQ = REQ | mask;
        model_push(mask);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge CLK);
            if (sb.size() == 0 && mstep == 0 && !BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: got busy=%0d pending=%0d expected idle", tag, BUSY, sb.size());
        end
    endtask

    // Requesters: drop REQ on ACK (or early during WRITE), and scramble data once it is sampled.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            for (int i = 0; i < int'(N); i++) begin
                if (REG_ENA && GNT[i]) begin
                    WDATA[i*W +: W] = W'($urandom);
                    if (early_ok && $urandom_range(0, 1) == 1) REQ[i] = 1'b0;
                end
                if (ACK[i]) REQ[i] = 1'b0;
            end
        end
    end

    // Monitor: each register write must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (mon_en) begin
            case (mstep)
                0: begin
                    if (REG_ENA) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_write", 32'(REG_ENA), 32'(0));
                        end else begin
                            cur = sb.pop_front();
                            chk("gnt_write", 32'(GNT), 32'(1) << cur.idx);
                            chk("reg_data", 32'(REG_DATA), 32'(cur.data));
                            chk("busy", 32'(BUSY), 32'(1));
                            mstep = 1;
                        end
                    end
                end
                1: begin
                    chk("ack", 32'(ACK), 32'(1) << cur.idx);
                    chk("ena_pulse", 32'(REG_ENA), 32'(0));
                    chk("readback", 32'(reg_r), 32'(cur.data));
                    chk("gnt_check", 32'(GNT), 32'(1) << cur.idx);
                    mstep = 2;
                end
                default: begin
                    chk("err_flag", 32'(ERR), 32'(cur.err));
                    chk("gnt_release", 32'(GNT), 32'(1) << cur.idx);
                    chk("ack_off", 32'(ACK), 32'(0));
                    mstep = 0;
                end
            endcase
        end
    end

    initial begin
        bit seen;
        n_cmp = 0; n_err = 0; model_ptr = 0; model_err = 1'b0;
        corrupt = 1'b0; mon_en = 1'b1; early_ok = 1'b0; mstep = 0;
        RST = 1'b0;
        WDATA = {8'h55, 8'hFF, 8'hF0, 8'h0F};
        REQ = 4'b1111;

        // Reset held with all requests asserted.
        repeat (2) begin
            @(negedge CLK);
            chk("rst_gnt", 32'(GNT), 32'(0));
            chk("rst_ack", 32'(ACK), 32'(0));
            chk("rst_ena", 32'(REG_ENA), 32'(0));
            chk("rst_busy", 32'(BUSY), 32'(0));
            chk("rst_err", 32'(ERR), 32'(0));
            chk("rst_data", 32'(REG_DATA), 32'(0));
        end
        RST = 1'b1;
        model_push(4'b1111);
        wait_done("fair");
        chk("final_r", 32'(reg_r), 32'h55);

        // Single write from requester 2.
        WDATA[2*W +: W] = 8'hAA;
        issue(4'b0100);
        wait_done("single");
        chk("single_err", 32'(ERR), 32'(0));

        // Pointer wrap.
        issue(4'b1000);
        wait_done("wrap_a");
        issue(4'b1001);
        wait_done("wrap_b");

        // Random request sets with early drops.
        early_ok = 1'b1;
        repeat (25) begin
            for (int i = 0; i < int'(N); i++) WDATA[i*W +: W] = W'($urandom);
            issue(N'($urandom_range(1, 15)));
            wait_done("rand");
        end
        early_ok = 1'b0;

        // Readback error is sticky across later good writes.
        corrupt = 1'b1;
        WDATA[1*W +: W] = 8'hAA;
        issue(4'b0010);
        wait_done("err");
        corrupt = 1'b0;
        chk("err_set", 32'(ERR), 32'(1));
        for (int i = 0; i < int'(N); i++) WDATA[i*W +: W] = W'($urandom);
        issue(4'b1111);
        wait_done("err_sticky");
        chk("err_sticky", 32'(ERR), 32'(1));

        // Reset during WRITE abandons the write.
        mon_en = 1'b0;
        WDATA[1*W +: W] = 8'h3C;
        REQ = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (REG_ENA) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midrst_write_seen", 32'(seen), 32'(1));
        RST = 1'b0;
        REQ = '0;
        @(negedge CLK);
        chk("midrst_gnt", 32'(GNT), 32'(0));
        chk("midrst_ack", 32'(ACK), 32'(0));
        chk("midrst_ena", 32'(REG_ENA), 32'(0));
        chk("midrst_busy", 32'(BUSY), 32'(0));
        chk("midrst_err", 32'(ERR), 32'(0));
        chk("midrst_data", 32'(REG_DATA), 32'(0));
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_ack_after", 32'(ACK), 32'(0));
        chk("midrst_busy_after", 32'(BUSY), 32'(0));
        model_ptr = 0;
        model_err = 1'b0;
        sb.delete();
        mstep = 0;
        mon_en = 1'b1;
        for (int i = 0; i < int'(N); i++) WDATA[i*W +: W] = W'($urandom);
        issue(4'b1111);
        wait_done("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
